// File: rtl/ram_writer_pkg.sv
// Shared types and default sizes for the RAM stream writer.
// Used by ram_stream_writer and its interface; see RAM_WRITER_CHECKSUM_EN in the top.
package ram_writer_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ram_stream_writer_if.sv
// Stream-in / async-read-out bundle for ram_stream_writer.
// CHECKSUM exists only when RAM_WRITER_CHECKSUM_EN is defined.
interface ram_stream_writer_if #(
   parameter int DATA_WIDTH = ram_writer_pkg::DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = ram_writer_pkg::DEFAULT_ADDR_WIDTH
);
   logic                  START;
   logic [DATA_WIDTH-1:0] DIN;
   logic                  DIN_VALID;
   logic                  DIN_READY;
   logic                  BUSY;
   logic                  DONE;
   logic [ADDR_WIDTH-1:0] WADDR;
   logic [ADDR_WIDTH-1:0] RADDR;
   logic [DATA_WIDTH-1:0] Q;
`ifdef RAM_WRITER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] CHECKSUM;

   modport master (
      output START, DIN, DIN_VALID, RADDR,
      input  DIN_READY, BUSY, DONE, WADDR, Q, CHECKSUM
   );
   modport slave (
      input  START, DIN, DIN_VALID, RADDR,
      output DIN_READY, BUSY, DONE, WADDR, Q, CHECKSUM
   );
`else
   modport master (
      output START, DIN, DIN_VALID, RADDR,
      input  DIN_READY, BUSY, DONE, WADDR, Q
   );
   modport slave (
      input  START, DIN, DIN_VALID, RADDR,
      output DIN_READY, BUSY, DONE, WADDR, Q
   );
`endif
endinterface

// File: rtl/single_port_ram_sync_wr.sv
// Single-port RAM: synchronous write, combinational (asynchronous) read.
// Contents are never reset.
module single_port_ram_sync_wr #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] WADDR,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic [ADDR_WIDTH-1:0] RADDR,
   output logic [DATA_WIDTH-1:0] Q
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge CLK) begin
      if (WE) begin
         mem[WADDR] <= D;
      end
   end

   // No write-through: a colliding read shows the old word until the edge.
   assign Q = mem[RADDR];

endmodule

// File: rtl/ram_stream_writer.sv
// Fills a RAM at addresses 0..DEPTH-1 from a valid/ready stream, async read port.
// Optional XOR checksum of the accepted words when RAM_WRITER_CHECKSUM_EN is defined.
module ram_stream_writer
   import ram_writer_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                CLK,
   input  logic                RESET,
   ram_stream_writer_if.slave  bus
);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

   state_t                state_reg;
   state_t                state_next;
   logic [ADDR_WIDTH-1:0] waddr_reg;
   logic [ADDR_WIDTH-1:0] waddr_next;
   logic                  we;
   logic                  start_accept;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_reg <= IDLE;
         waddr_reg <= '0;
      end else begin
         state_reg <= state_next;
         waddr_reg <= waddr_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      waddr_next   = waddr_reg;
      we           = 1'b0;
      start_accept = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (bus.START) begin
               start_accept = 1'b1;
               state_next   = FILL;
               waddr_next   = '0;
            end
         end
         FILL: begin
            // START is deliberately not looked at here: a fill always completes.
            if (bus.DIN_VALID) begin
               we         = 1'b1;
               waddr_next = waddr_reg + ADDR_WIDTH'(1);
               if (waddr_reg == LAST_ADDR) begin
                  state_next = DONE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            waddr_next = '0;
         end
      endcase
   end

   assign bus.BUSY      = (state_reg == FILL);
   assign bus.DIN_READY = (state_reg == FILL);
   assign bus.DONE      = (state_reg == DONE);
   assign bus.WADDR     = waddr_reg;

`ifdef RAM_WRITER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] checksum_reg;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         checksum_reg <= '0;
      end else if (start_accept) begin
         checksum_reg <= '0;
      end else if (we) begin
         checksum_reg <= checksum_reg ^ bus.DIN;
      end
   end

   assign bus.CHECKSUM = checksum_reg;
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
`endif

   single_port_ram_sync_wr #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .CLK   (CLK),
      .WE    (we),
      .WADDR (waddr_reg),
      .D     (bus.DIN),
      .RADDR (bus.RADDR),
      .Q     (bus.Q)
   );

endmodule
